// File: rtl/img_rsz_frm_ctrl.sv
// Frame sequencer for the image resizer: validates the frame size, tags the raw pixel
// stream with raster coordinates and tracks resized-output completion and drain timeouts.
module img_rsz_frm_ctrl #(
    parameter int IMG_WIDTH_IDX_W  = 12,
    parameter int IMG_HEIGHT_IDX_W = 12,
    parameter int PXL_DATA_W       = 24,
    parameter int RSZ_WIDTH_SIZE   = 32,
    parameter int RSZ_HEIGHT_SIZE  = 16,
    parameter int DRAIN_TMO        = 1024,
    localparam int RSZ_TOTAL       = RSZ_WIDTH_SIZE * RSZ_HEIGHT_SIZE,
    localparam int CNT_W           = $clog2(RSZ_TOTAL + 1)
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        CfgStart,
    input  logic [IMG_WIDTH_IDX_W-1:0]  CfgWidth,
    input  logic [IMG_HEIGHT_IDX_W-1:0] CfgHeight,
    input  logic                        CfgAbort,
    output logic                        Busy,
    output logic                        Done,
    output logic                        CfgErr,
    output logic                        TmoErr,
    input  logic [PXL_DATA_W-1:0]       SrcData,
    input  logic                        SrcVld,
    output logic                        SrcRdy,
    output logic [PXL_DATA_W-1:0]       PxlData,
    output logic [IMG_WIDTH_IDX_W-1:0]  PxlX,
    output logic [IMG_HEIGHT_IDX_W-1:0] PxlY,
    output logic [IMG_WIDTH_IDX_W-1:0]  ImgWidth,
    output logic [IMG_HEIGHT_IDX_W-1:0] ImgHeight,
    output logic                        PxlVld,
    input  logic                        PxlRdy,
    input  logic                        RszPxlVld,
    input  logic                        RszPxlRdy,
    output logic [CNT_W-1:0]            RszCnt
);
    localparam int TMO_W = $clog2(DRAIN_TMO + 1);
    localparam logic [IMG_WIDTH_IDX_W-1:0]  MIN_W = IMG_WIDTH_IDX_W'(RSZ_WIDTH_SIZE);
    localparam logic [IMG_HEIGHT_IDX_W-1:0] MIN_H = IMG_HEIGHT_IDX_W'(RSZ_HEIGHT_SIZE);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} stateT;

    stateT                        stateReg;
    logic [IMG_WIDTH_IDX_W-1:0]   xReg, widthReg;
    logic [IMG_HEIGHT_IDX_W-1:0]  yReg, heightReg;
    logic [CNT_W-1:0]             rszCntReg;
    logic [TMO_W-1:0]             tmoCntReg;
    logic                         cfgErrReg, tmoErrReg;

    logic streaming, inHs, rszHs, rszFull, rszFullNext, lastCol, lastRow, cfgOk;

    // Abort gates the pass-through combinationally so no pixel is half-transferred.
    assign streaming   = (stateReg == STREAM) && !CfgAbort;
    assign SrcRdy      = PxlRdy & streaming;
    assign PxlVld      = SrcVld & streaming;
    assign PxlData     = SrcData;
    assign inHs        = SrcVld & SrcRdy;
    assign rszHs       = RszPxlVld & RszPxlRdy & ((stateReg == STREAM) || (stateReg == DRAIN));
    assign rszFull     = (rszCntReg == CNT_W'(RSZ_TOTAL));
    assign rszFullNext = rszFull | (rszHs & (rszCntReg == CNT_W'(RSZ_TOTAL - 1)));
    assign lastCol     = (xReg == widthReg - IMG_WIDTH_IDX_W'(1));
    assign lastRow     = (yReg == heightReg - IMG_HEIGHT_IDX_W'(1));
    assign cfgOk       = (CfgWidth >= MIN_W) && (CfgHeight >= MIN_H);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateReg  <= IDLE;
            xReg      <= '0;
            yReg      <= '0;
            widthReg  <= '0;
            heightReg <= '0;
            rszCntReg <= '0;
            tmoCntReg <= '0;
            cfgErrReg <= 1'b0;
            tmoErrReg <= 1'b0;
        end else begin
            cfgErrReg <= 1'b0;
            tmoErrReg <= 1'b0;
            if (rszHs && !rszFull)
                rszCntReg <= rszCntReg + CNT_W'(1);

            if (CfgAbort && stateReg != IDLE) begin
                stateReg  <= IDLE;
                xReg      <= '0;
                yReg      <= '0;
                rszCntReg <= '0;
                tmoCntReg <= '0;
            end else begin
                case (stateReg)
                    IDLE: begin
                        if (CfgStart) begin
                            if (cfgOk) begin
                                widthReg  <= CfgWidth;
                                heightReg <= CfgHeight;
                                xReg      <= '0;
                                yReg      <= '0;
                                rszCntReg <= '0;
                                tmoCntReg <= '0;
                                stateReg  <= STREAM;
                            end else begin
                                cfgErrReg <= 1'b1;
                            end
                        end
                    end
                    STREAM: begin
                        if (inHs) begin
                            if (lastCol) begin
                                // Coordinates freeze on the final pixel of the frame.
                                if (lastRow) begin
                                    stateReg <= rszFullNext ? DONE : DRAIN;
                                end else begin
                                    xReg <= '0;
                                    yReg <= yReg + IMG_HEIGHT_IDX_W'(1);
                                end
                            end else begin
                                xReg <= xReg + IMG_WIDTH_IDX_W'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        if (rszFullNext) begin
                            stateReg <= DONE;
                        end else if (rszHs) begin
                            tmoCntReg <= '0;
                        end else if (tmoCntReg == TMO_W'(DRAIN_TMO - 1)) begin
                            tmoErrReg <= 1'b1;
                            stateReg  <= IDLE;
                        end else begin
                            tmoCntReg <= tmoCntReg + TMO_W'(1);
                        end
                    end
                    default: stateReg <= IDLE;
                endcase
            end
        end
    end

    assign Busy      = (stateReg != IDLE);
    assign Done      = (stateReg == DONE);
    assign CfgErr    = cfgErrReg;
    assign TmoErr    = tmoErrReg;
    assign PxlX      = xReg;
    assign PxlY      = yReg;
    assign ImgWidth  = widthReg;
    assign ImgHeight = heightReg;
    assign RszCnt    = rszCntReg;
endmodule

// File: tb/tb_img_rsz_frm_ctrl.sv
// Directed bench for img_rsz_frm_ctrl: full frames, stalls, size errors, abort,
// drain timeout and ignored mid-frame start requests.
module tb_img_rsz_frm_ctrl;
    localparam int TMO = 1024;

    logic        Clk = 1'b0;
    logic        Reset, CfgStart, CfgAbort;
    logic [11:0] CfgWidth, CfgHeight;
    logic        Busy, Done, CfgErr, TmoErr;
    logic [23:0] SrcData, PxlData;
    logic        SrcVld, SrcRdy, PxlVld, PxlRdy, RszPxlVld, RszPxlRdy;
    logic [11:0] PxlX, ImgWidth;
    logic [11:0] PxlY, ImgHeight;
    logic [9:0]  RszCnt;

    int errors = 0;
    int checks = 0;

    img_rsz_frm_ctrl dut (
        .Clk(Clk), .Reset(Reset), .CfgStart(CfgStart), .CfgWidth(CfgWidth),
        .CfgHeight(CfgHeight), .CfgAbort(CfgAbort), .Busy(Busy), .Done(Done),
        .CfgErr(CfgErr), .TmoErr(TmoErr), .SrcData(SrcData), .SrcVld(SrcVld),
        .SrcRdy(SrcRdy), .PxlData(PxlData), .PxlX(PxlX), .PxlY(PxlY),
        .ImgWidth(ImgWidth), .ImgHeight(ImgHeight), .PxlVld(PxlVld), .PxlRdy(PxlRdy),
        .RszPxlVld(RszPxlVld), .RszPxlRdy(RszPxlRdy), .RszCnt(RszCnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        CfgStart = 0; CfgAbort = 0; SrcVld = 0; PxlRdy = 0;
        RszPxlVld = 0; RszPxlRdy = 0; SrcData = '0;
    endtask

    task automatic start_frame(input int w, input int h);
        @(negedge Clk);
        CfgStart = 1; CfgWidth = 12'(w); CfgHeight = 12'(h);
        @(negedge Clk);
        CfgStart = 0;
    endtask

    // Streams one whole frame against a raster model; optional stalls and a mid-frame start.
    task automatic run_frame(input int w, input int h, input bit stall, input bit midStart);
        int ex = 0, ey = 0, inCnt = 0, outCnt = 0, doneCnt = 0, cyc = 0;
        bit fin = 0, badPulse = 0;
        start_frame(w, h);
        chk_eq("frame_busy", Busy, 1);
        chk_eq("frame_x0", PxlX, 0);
        chk_eq("frame_y0", PxlY, 0);
        while (!fin && cyc < 60000) begin
            if (Done) begin
                doneCnt++;
                chk_eq("done_in_cnt", inCnt, w * h);
                chk_eq("done_out_cnt", outCnt, 512);
            end
            if (CfgErr || TmoErr) badPulse = 1;
            if (!Busy) begin
                fin = 1;
            end else begin
                SrcVld    = (inCnt < w * h) && (!stall || $urandom_range(2) != 0);
                SrcData   = 24'($urandom);
                PxlRdy    = !stall || $urandom_range(2) != 0;
                RszPxlVld = (outCnt < 512) && (!stall || $urandom_range(2) != 0);
                RszPxlRdy = !stall || $urandom_range(2) != 0;
                CfgStart  = midStart && inCnt == 100;
                CfgWidth  = 12'd200; CfgHeight = 12'd100;
                #1;
                if (SrcVld && SrcRdy) begin
                    chk_eq("pxl_x", PxlX, ex);
                    chk_eq("pxl_y", PxlY, ey);
                    chk_eq("pxl_vld", PxlVld, 1);
                    chk_eq("pxl_data", PxlData, SrcData);
                    inCnt++;
                    if (ex == w - 1) begin ex = 0; ey++; end else ex++;
                end
                if (RszPxlVld && RszPxlRdy) outCnt++;
                @(negedge Clk);
                cyc++;
            end
        end
        idle_inputs();
        chk_eq("frame_no_hang", cyc < 60000, 1);
        chk_eq("done_once", doneCnt, 1);
        chk_eq("no_err_pulse", badPulse, 0);
        chk_eq("last_x", PxlX, w - 1);
        chk_eq("last_y", PxlY, h - 1);
        chk_eq("rsz_cnt", RszCnt, 512);
        chk_eq("img_w", ImgWidth, w);
        chk_eq("img_h", ImgHeight, h);
        $display("frame %0dx%0d stall=%0d midstart=%0d: in=%0d out=%0d done=%0d cycles=%0d",
                 w, h, stall, midStart, inCnt, outCnt, doneCnt, cyc);
    endtask

    task automatic cfg_err_case(input int w, input int h);
        @(negedge Clk);
        CfgStart = 1; CfgWidth = 12'(w); CfgHeight = 12'(h);
        @(negedge Clk);
        CfgStart = 0; SrcVld = 1; PxlRdy = 1;
        #1;
        chk_eq("cfgerr_pulse", CfgErr, 1);
        chk_eq("cfgerr_busy", Busy, 0);
        chk_eq("cfgerr_srcrdy", SrcRdy, 0);
        @(negedge Clk);
        chk_eq("cfgerr_one_cycle", CfgErr, 0);
        chk_eq("cfgerr_still_idle", Busy, 0);
        idle_inputs();
        $display("cfg %0dx%0d rejected", w, h);
    endtask

    initial begin
        int ex, ey, cnt;
        bit sawDone;
        Reset = 1; CfgWidth = '0; CfgHeight = '0;
        idle_inputs();
        repeat (3) @(negedge Clk);
        chk_eq("rst_busy", Busy, 0);
        chk_eq("rst_done", Done, 0);
        chk_eq("rst_cfgerr", CfgErr, 0);
        chk_eq("rst_tmoerr", TmoErr, 0);
        chk_eq("rst_x", PxlX, 0);
        chk_eq("rst_y", PxlY, 0);
        chk_eq("rst_w", ImgWidth, 0);
        chk_eq("rst_h", ImgHeight, 0);
        chk_eq("rst_rszcnt", RszCnt, 0);
        Reset = 0;

        run_frame(129, 65, 0, 0);
        run_frame(129, 65, 1, 0);

        cfg_err_case(31, 65);
        cfg_err_case(129, 15);

        // Smallest legal size is accepted.
        start_frame(32, 16);
        chk_eq("min_size_busy", Busy, 1);
        chk_eq("min_size_noerr", CfgErr, 0);
        CfgAbort = 1;
        @(negedge Clk);
        CfgAbort = 0;
        chk_eq("min_size_abort_idle", Busy, 0);
        $display("cfg 32x16 accepted then aborted");

        // Abort at pixel (40,20).
        start_frame(129, 65);
        ex = 0; ey = 0; cnt = 0;
        SrcVld = 1; PxlRdy = 1;
        while (!(ex == 40 && ey == 20) && cnt < 5000) begin
            #1;
            if (SrcVld && SrcRdy) begin
                if (ex == 128) begin ex = 0; ey++; end else ex++;
            end
            @(negedge Clk);
            cnt++;
        end
        CfgAbort = 1;
        #1;
        chk_eq("abort_x", PxlX, 40);
        chk_eq("abort_y", PxlY, 20);
        chk_eq("abort_srcrdy_now", SrcRdy, 0);
        @(negedge Clk);
        CfgAbort = 0;
        #1;
        chk_eq("abort_idle", Busy, 0);
        chk_eq("abort_srcrdy", SrcRdy, 0);
        chk_eq("abort_x_clr", PxlX, 0);
        chk_eq("abort_y_clr", PxlY, 0);
        sawDone = 0;
        repeat (5) begin @(negedge Clk); if (Done) sawDone = 1; end
        chk_eq("abort_no_done", sawDone, 0);
        idle_inputs();
        $display("abort at (40,20) after %0d pixels", cnt);
        run_frame(129, 65, 0, 0);

        // Drain timeout after 500 outputs.
        start_frame(129, 65);
        SrcVld = 1; PxlRdy = 1;
        repeat (129 * 65) @(negedge Clk);
        SrcVld = 0;
        chk_eq("tmo_in_drain", Busy, 1);
        chk_eq("tmo_last_x", PxlX, 128);
        RszPxlVld = 1; RszPxlRdy = 1;
        repeat (500) @(negedge Clk);
        RszPxlVld = 0;
        chk_eq("tmo_rszcnt", RszCnt, 500);
        cnt = 0; sawDone = 0;
        while (!TmoErr && cnt < 3000) begin
            @(negedge Clk);
            cnt++;
            if (Done) sawDone = 1;
        end
        chk_eq("tmo_delay", cnt, TMO);
        chk_eq("tmo_idle", Busy, 0);
        chk_eq("tmo_no_done", sawDone, 0);
        @(negedge Clk);
        chk_eq("tmo_one_cycle", TmoErr, 0);
        idle_inputs();
        $display("drain timeout after %0d idle cycles", cnt);

        // Start request while streaming is ignored.
        run_frame(129, 65, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
